// File: rtl/pipe_control.sv
// Pipelined main control: decodes the ID opcode into a control bundle, carries it with the
// destination register through ID/EX, EX/MEM and MEM/WB, and resolves load-use, branch and jump hazards.
module pipe_control #(
    parameter int RA_W      = 5,
    parameter bit HAZARD_EN = 1'b1,
    parameter bit EXT_OPS   = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      op_id,
    input  logic [RA_W-1:0] rs_id,
    input  logic [RA_W-1:0] rt_id,
    input  logic [RA_W-1:0] rd_id,
    input  logic            zero_mem,
    output logic            ex_regdst,
    output logic            ex_alusrc,
    output logic [2:0]      ex_alu_mode,
    output logic            mem_read,
    output logic            mem_write,
    output logic            wb_memtoreg,
    output logic            wb_regwrite,
    output logic [RA_W-1:0] ex_dst,
    output logic [RA_W-1:0] mem_dst,
    output logic [RA_W-1:0] wb_dst,
    output logic            stall,
    output logic            flush_ifid,
    output logic [1:0]      pc_src,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic [2:0] alu_mode;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       branch_eq;
        logic       branch_ne;
    } ctrl_t;

    ctrl_t           id_ctrl;
    ctrl_t           idex_q;
    logic            jump_id;
    logic            uses_rs;
    logic            uses_rt;
    logic            dst_is_rt;
    logic [RA_W-1:0] id_dst;
    logic [RA_W-1:0] idex_dst_q;

    // EX/MEM and MEM/WB only keep the fields that later stages still consume
    logic            mem_read_q, mem_write_q, mem_memtoreg_q, mem_regwrite_q;
    logic            mem_beq_q, mem_bne_q;
    logic [RA_W-1:0] mem_dst_q;
    logic            wb_memtoreg_q, wb_regwrite_q;
    logic [RA_W-1:0] wb_dst_q;

    logic            take;
    logic            hazard;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_comb begin
        id_ctrl   = '0;
        jump_id   = 1'b0;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        dst_is_rt = 1'b0;
        case (op_id)
            OP_R: begin
                id_ctrl.regdst   = 1'b1;
                id_ctrl.alu_mode = 3'b010;
                id_ctrl.regwrite = 1'b1;
                uses_rs          = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_LW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memread  = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                id_ctrl.regwrite = 1'b1;
                uses_rs          = 1'b1;
                dst_is_rt        = 1'b1;
            end
            OP_SW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memwrite = 1'b1;
                uses_rs          = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl.alu_mode  = 3'b001;
                id_ctrl.branch_eq = 1'b1;
                uses_rs           = 1'b1;
                uses_rt           = 1'b1;
            end
            OP_BNE: begin
                if (EXT_OPS) begin
                    id_ctrl.alu_mode  = 3'b001;
                    id_ctrl.branch_ne = 1'b1;
                    uses_rs           = 1'b1;
                    uses_rt           = 1'b1;
                end
            end
            OP_J: jump_id = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI: begin
                if (EXT_OPS) begin
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                    uses_rs          = 1'b1;
                    dst_is_rt        = 1'b1;
                    if (op_id == OP_ANDI)
                        id_ctrl.alu_mode = 3'b011;
                    else if (op_id == OP_ORI)
                        id_ctrl.alu_mode = 3'b100;
                    else
                        id_ctrl.alu_mode = 3'b000;
                end
            end
            default: ;
        endcase
    end

    assign id_dst = id_ctrl.regdst ? rd_id : (dst_is_rt ? rt_id : '0);

    // A taken branch in MEM outranks both the load-use stall and a jump in ID
    always_comb begin
        take   = (mem_beq_q & zero_mem) | (mem_bne_q & ~zero_mem);
        hazard = HAZARD_EN && idex_q.memread && (idex_dst_q != '0) &&
                 (((idex_dst_q == rs_id) && uses_rs) || ((idex_dst_q == rt_id) && uses_rt));
        stall      = hazard & ~take;
        flush_ifid = take | jump_id;
        if (take)
            pc_src = 2'b01;
        else if (jump_id)
            pc_src = 2'b10;
        else
            pc_src = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q         <= '0;
            idex_dst_q     <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_beq_q      <= 1'b0;
            mem_bne_q      <= 1'b0;
            mem_dst_q      <= '0;
            wb_memtoreg_q  <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_dst_q       <= '0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            wb_memtoreg_q <= mem_memtoreg_q;
            wb_regwrite_q <= mem_regwrite_q;
            wb_dst_q      <= mem_dst_q;
            if (take) begin
                idex_q         <= '0;
                idex_dst_q     <= '0;
                mem_read_q     <= 1'b0;
                mem_write_q    <= 1'b0;
                mem_memtoreg_q <= 1'b0;
                mem_regwrite_q <= 1'b0;
                mem_beq_q      <= 1'b0;
                mem_bne_q      <= 1'b0;
                mem_dst_q      <= '0;
            end else begin
                mem_read_q     <= idex_q.memread;
                mem_write_q    <= idex_q.memwrite;
                mem_memtoreg_q <= idex_q.memtoreg;
                mem_regwrite_q <= idex_q.regwrite;
                mem_beq_q      <= idex_q.branch_eq;
                mem_bne_q      <= idex_q.branch_ne;
                mem_dst_q      <= idex_dst_q;
                if (stall) begin
                    idex_q     <= '0;
                    idex_dst_q <= '0;
                end else begin
                    idex_q     <= id_ctrl;
                    idex_dst_q <= id_dst;
                end
            end
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_ifid && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign ex_regdst   = idex_q.regdst;
    assign ex_alusrc   = idex_q.alusrc;
    assign ex_alu_mode = idex_q.alu_mode;
    assign ex_dst      = idex_dst_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_dst     = mem_dst_q;
    assign wb_memtoreg = wb_memtoreg_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_dst      = wb_dst_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: a default instance, one with HAZARD_EN=0/EXT_OPS=0,
// and one with CNT_W=2, all driven by the same instruction stream.
module tb_pipe_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_UND  = 6'b111111;
    localparam logic [5:0] OP_NOP  = 6'b110000;

    logic       clk;
    logic       reset;
    logic [5:0] op_id;
    logic [4:0] rs_id, rt_id, rd_id;
    logic       zero_mem;

    logic        ex_regdst, ex_alusrc, mem_read, mem_write, wb_memtoreg, wb_regwrite;
    logic [2:0]  ex_alu_mode;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic        stall, flush_ifid;
    logic [1:0]  pc_src;
    logic [15:0] stall_cnt, flush_cnt;

    logic        a_ex_regdst, a_ex_alusrc, a_mem_read, a_mem_write, a_wb_memtoreg, a_wb_regwrite;
    logic [2:0]  a_ex_alu_mode;
    logic [4:0]  a_ex_dst, a_mem_dst, a_wb_dst;
    logic        a_stall, a_flush_ifid;
    logic [1:0]  a_pc_src;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    logic        c_ex_regdst, c_ex_alusrc, c_mem_read, c_mem_write, c_wb_memtoreg, c_wb_regwrite;
    logic [2:0]  c_ex_alu_mode;
    logic [4:0]  c_ex_dst, c_mem_dst, c_wb_dst;
    logic        c_stall, c_flush_ifid;
    logic [1:0]  c_pc_src;
    logic [1:0]  c_stall_cnt, c_flush_cnt;

    pipe_control dut (
        .clk(clk), .reset(reset), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .zero_mem(zero_mem), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_alu_mode(ex_alu_mode),
        .mem_read(mem_read), .mem_write(mem_write), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst), .stall(stall), .flush_ifid(flush_ifid),
        .pc_src(pc_src), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_control #(.HAZARD_EN(1'b0), .EXT_OPS(1'b0)) dut_alt (
        .clk(clk), .reset(reset), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .zero_mem(zero_mem), .ex_regdst(a_ex_regdst), .ex_alusrc(a_ex_alusrc), .ex_alu_mode(a_ex_alu_mode),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .wb_memtoreg(a_wb_memtoreg), .wb_regwrite(a_wb_regwrite),
        .ex_dst(a_ex_dst), .mem_dst(a_mem_dst), .wb_dst(a_wb_dst), .stall(a_stall), .flush_ifid(a_flush_ifid),
        .pc_src(a_pc_src), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_control #(.CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .zero_mem(zero_mem), .ex_regdst(c_ex_regdst), .ex_alusrc(c_ex_alusrc), .ex_alu_mode(c_ex_alu_mode),
        .mem_read(c_mem_read), .mem_write(c_mem_write), .wb_memtoreg(c_wb_memtoreg), .wb_regwrite(c_wb_regwrite),
        .ex_dst(c_ex_dst), .mem_dst(c_mem_dst), .wb_dst(c_wb_dst), .stall(c_stall), .flush_ifid(c_flush_ifid),
        .pc_src(c_pc_src), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        O_EXB, O_EXDST, O_MEMB, O_MEMDST, O_WBB, O_WBDST, O_STALL, O_FLUSH, O_PC, O_SCNT, O_FCNT,
        A_EXB, A_EXDST, A_STALL, A_PC, C_SCNT
    } obs_e;

    typedef struct {
        int          due;
        string       name;
        obs_e        sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;

    // EX bundle packs as {regdst, alusrc, alu_mode}; MEM as {read, write}; WB as {memtoreg, regwrite}
    function automatic logic [15:0] observe(obs_e sel);
        case (sel)
            O_EXB:    return {11'd0, ex_regdst, ex_alusrc, ex_alu_mode};
            O_EXDST:  return {11'd0, ex_dst};
            O_MEMB:   return {14'd0, mem_read, mem_write};
            O_MEMDST: return {11'd0, mem_dst};
            O_WBB:    return {14'd0, wb_memtoreg, wb_regwrite};
            O_WBDST:  return {11'd0, wb_dst};
            O_STALL:  return {15'd0, stall};
            O_FLUSH:  return {15'd0, flush_ifid};
            O_PC:     return {14'd0, pc_src};
            O_SCNT:   return stall_cnt;
            O_FCNT:   return flush_cnt;
            A_EXB:    return {11'd0, a_ex_regdst, a_ex_alusrc, a_ex_alu_mode};
            A_EXDST:  return {11'd0, a_ex_dst};
            A_STALL:  return {15'd0, a_stall};
            A_PC:     return {14'd0, a_pc_src};
            C_SCNT:   return {14'd0, c_stall_cnt};
            default:  return 16'hdead;
        endcase
    endfunction

    task automatic expect_at(input int lat, input string name, input obs_e sel, input logic [15:0] val);
        sb.push_back('{cyc + lat, name, sel, val});
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd);
        op_id = op;
        rs_id = rs;
        rt_id = rt;
        rd_id = rd;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin reset = 1'b1; zero_mem = 1'b0; applyStimulus(OP_LW, 5'd0, 5'd7, 5'd0); end
                1: for (int s = 0; s <= int'(O_FCNT); s++) expect_at(0, "reset_zero", obs_e'(s), 16'd0);
                2: begin
                    reset = 1'b0;
                    for (int s = 0; s <= int'(O_FCNT); s++) expect_at(0, "reset_zero_held", obs_e'(s), 16'd0);
                    expect_at(1, "lw_ex_bundle", O_EXB, 16'h08);
                    expect_at(1, "lw_ex_dst", O_EXDST, 16'd7);
                    expect_at(2, "lw_mem_bundle", O_MEMB, 16'h2);
                    expect_at(3, "lw_wb_bundle", O_WBB, 16'h3);
                    expect_at(3, "lw_wb_dst", O_WBDST, 16'd7);
                end
                3: applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
                default: ;
            endcase
            @(negedge clk);
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    obs = observe(sb[k].sel);
                    tests++;
                    if (obs !== sb[k].val) begin
                        failed++;
                        $display("[TB] FAIL %s: observed %0h, expected %0h", sb[k].name, obs, sb[k].val);
                    end
                    sb.delete(k);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_load_use();
        logic [15:0] obs;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin
                    applyStimulus(OP_LW, 5'd1, 5'd5, 5'd0);
                    expect_at(0, "hz_lw_nostall", O_STALL, 16'd0);
                    expect_at(1, "hz_lw_ex", O_EXB, 16'h08);
                    expect_at(1, "hz_lw_exdst", O_EXDST, 16'd5);
                end
                1: begin
                    applyStimulus(OP_R, 5'd5, 5'd2, 5'd9);
                    expect_at(0, "hz_stall", O_STALL, 16'd1);
                    expect_at(0, "hz_nohazard_inst_stall", A_STALL, 16'd0);
                    expect_at(1, "hz_bubble_ex", O_EXB, 16'd0);
                    expect_at(1, "hz_bubble_dst", O_EXDST, 16'd0);
                    expect_at(1, "hz_lw_memdst", O_MEMDST, 16'd5);
                    expect_at(1, "hz_scnt", O_SCNT, 16'd1);
                end
                2: begin
                    expect_at(0, "hz_stall_once", O_STALL, 16'd0);
                    expect_at(1, "hz_r_ex", O_EXB, 16'h12);
                    expect_at(1, "hz_r_exdst", O_EXDST, 16'd9);
                end
                3: applyStimulus(OP_LW, 5'd0, 5'd0, 5'd0);
                4: begin
                    applyStimulus(OP_R, 5'd0, 5'd0, 5'd3);
                    expect_at(0, "hz_rt0_nostall", O_STALL, 16'd0);
                end
                5: begin
                    applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
                    expect_at(0, "hz_scnt_final", O_SCNT, 16'd1);
                end
                default: ;
            endcase
            @(negedge clk);
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    obs = observe(sb[k].sel);
                    tests++;
                    if (obs !== sb[k].val) begin
                        failed++;
                        $display("[TB] FAIL %s: observed %0h, expected %0h", sb[k].name, obs, sb[k].val);
                    end
                    sb.delete(k);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_branch_beq();
        logic [15:0] obs;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin
                    zero_mem = 1'b0;
                    applyStimulus(OP_BEQ, 5'd1, 5'd2, 5'd0);
                    expect_at(1, "beq_ex", O_EXB, 16'h01);
                end
                1: applyStimulus(OP_R, 5'd1, 5'd2, 5'd4);
                2: begin
                    applyStimulus(OP_R, 5'd1, 5'd2, 5'd6);
                    zero_mem = 1'b1;
                    expect_at(0, "beq_pc", O_PC, 16'd1);
                    expect_at(0, "beq_flush", O_FLUSH, 16'd1);
                    expect_at(1, "beq_flushed_ex", O_EXB, 16'd0);
                    expect_at(1, "beq_flushed_exdst", O_EXDST, 16'd0);
                    expect_at(1, "beq_flushed_mem", O_MEMB, 16'd0);
                    expect_at(1, "beq_flushed_memdst", O_MEMDST, 16'd0);
                    expect_at(1, "beq_fcnt", O_FCNT, 16'd1);
                end
                3: begin zero_mem = 1'b0; applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0); end
                4: applyStimulus(OP_BEQ, 5'd1, 5'd2, 5'd0);
                5: applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
                6: begin
                    expect_at(0, "beq_nt_pc", O_PC, 16'd0);
                    expect_at(0, "beq_nt_flush", O_FLUSH, 16'd0);
                    expect_at(1, "beq_nt_fcnt", O_FCNT, 16'd1);
                end
                default: ;
            endcase
            @(negedge clk);
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    obs = observe(sb[k].sel);
                    tests++;
                    if (obs !== sb[k].val) begin
                        failed++;
                        $display("[TB] FAIL %s: observed %0h, expected %0h", sb[k].name, obs, sb[k].val);
                    end
                    sb.delete(k);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_ext_ops();
        logic [15:0] obs;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin
                    zero_mem = 1'b0;
                    applyStimulus(OP_BNE, 5'd1, 5'd2, 5'd0);
                    expect_at(1, "bne_ex", O_EXB, 16'h01);
                    expect_at(1, "bne_noext_ex", A_EXB, 16'd0);
                end
                1: applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
                2: begin
                    expect_at(0, "bne_pc", O_PC, 16'd1);
                    expect_at(0, "bne_noext_pc", A_PC, 16'd0);
                    expect_at(1, "bne_fcnt", O_FCNT, 16'd2);
                end
                3: begin
                    applyStimulus(OP_ADDI, 5'd1, 5'd12, 5'd0);
                    expect_at(1, "addi_ex", O_EXB, 16'h08);
                    expect_at(1, "addi_dst", O_EXDST, 16'd12);
                    expect_at(1, "addi_noext_ex", A_EXB, 16'd0);
                    expect_at(1, "addi_noext_dst", A_EXDST, 16'd0);
                end
                4: begin
                    applyStimulus(OP_ANDI, 5'd1, 5'd13, 5'd0);
                    expect_at(1, "andi_ex", O_EXB, 16'h0b);
                    expect_at(3, "andi_wb_dst", O_WBDST, 16'd13);
                end
                5: begin
                    applyStimulus(OP_ORI, 5'd1, 5'd14, 5'd0);
                    expect_at(1, "ori_ex", O_EXB, 16'h0c);
                end
                6: begin
                    applyStimulus(OP_SW, 5'd1, 5'd2, 5'd0);
                    expect_at(1, "sw_ex", O_EXB, 16'h08);
                    expect_at(1, "sw_dst", O_EXDST, 16'd0);
                    expect_at(2, "sw_mem", O_MEMB, 16'h1);
                end
                7: applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
                default: ;
            endcase
            @(negedge clk);
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    obs = observe(sb[k].sel);
                    tests++;
                    if (obs !== sb[k].val) begin
                        failed++;
                        $display("[TB] FAIL %s: observed %0h, expected %0h", sb[k].name, obs, sb[k].val);
                    end
                    sb.delete(k);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_priority();
        logic [15:0] obs;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin zero_mem = 1'b0; applyStimulus(OP_BEQ, 5'd1, 5'd2, 5'd0); end
                1: applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
                2: begin
                    applyStimulus(OP_J, 5'd0, 5'd7, 5'd7);
                    zero_mem = 1'b1;
                    expect_at(0, "jb_pc", O_PC, 16'd1);
                    expect_at(0, "jb_flush", O_FLUSH, 16'd1);
                    expect_at(1, "jb_fcnt", O_FCNT, 16'd3);
                end
                3: begin
                    zero_mem = 1'b0;
                    expect_at(0, "j_pc", O_PC, 16'd2);
                    expect_at(0, "j_flush", O_FLUSH, 16'd1);
                    expect_at(0, "j_nostall", O_STALL, 16'd0);
                    expect_at(1, "j_ex", O_EXB, 16'd0);
                    expect_at(1, "j_exdst", O_EXDST, 16'd0);
                    expect_at(1, "j_fcnt", O_FCNT, 16'd4);
                end
                4: applyStimulus(OP_BEQ, 5'd1, 5'd2, 5'd0);
                5: applyStimulus(OP_LW, 5'd0, 5'd8, 5'd0);
                6: begin
                    applyStimulus(OP_R, 5'd8, 5'd0, 5'd3);
                    zero_mem = 1'b1;
                    expect_at(0, "bh_stall", O_STALL, 16'd0);
                    expect_at(0, "bh_pc", O_PC, 16'd1);
                    expect_at(1, "bh_scnt", O_SCNT, 16'd1);
                    expect_at(1, "bh_fcnt", O_FCNT, 16'd5);
                end
                7: begin zero_mem = 1'b0; applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0); end
                default: ;
            endcase
            @(negedge clk);
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    obs = observe(sb[k].sel);
                    tests++;
                    if (obs !== sb[k].val) begin
                        failed++;
                        $display("[TB] FAIL %s: observed %0h, expected %0h", sb[k].name, obs, sb[k].val);
                    end
                    sb.delete(k);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    // Each lw/dependent pair gives one stall; the 2-bit counter must stop at 3
    task automatic test_saturation_undef();
        logic [15:0] obs;
        int          n;
        for (int i = 0; i < 20; i++) begin
            if (i < 15) begin
                n = i / 3;
                case (i % 3)
                    0: applyStimulus(OP_LW, 5'd1, 5'd5, 5'd0);
                    1: begin
                        applyStimulus(OP_R, 5'd5, 5'd2, 5'd9);
                        expect_at(0, "sat_stall", O_STALL, 16'd1);
                        expect_at(1, "sat_scnt", O_SCNT, 16'(2 + n));
                        expect_at(1, "sat_c2_scnt", C_SCNT, 16'((2 + n > 3) ? 3 : 2 + n));
                    end
                    default: ;
                endcase
            end else if (i == 15) begin
                applyStimulus(OP_UND, 5'd1, 5'd2, 5'd3);
                expect_at(0, "und_stall", O_STALL, 16'd0);
                expect_at(0, "und_flush", O_FLUSH, 16'd0);
                expect_at(1, "und_ex", O_EXB, 16'd0);
                expect_at(1, "und_exdst", O_EXDST, 16'd0);
                expect_at(2, "und_mem", O_MEMB, 16'd0);
                expect_at(2, "und_memdst", O_MEMDST, 16'd0);
                expect_at(3, "und_wb", O_WBB, 16'd0);
                expect_at(3, "und_wbdst", O_WBDST, 16'd0);
            end else begin
                applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
            end
            @(negedge clk);
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    obs = observe(sb[k].sel);
                    tests++;
                    if (obs !== sb[k].val) begin
                        failed++;
                        $display("[TB] FAIL %s: observed %0h, expected %0h", sb[k].name, obs, sb[k].val);
                    end
                    sb.delete(k);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [15:0] obs;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: applyStimulus(OP_LW, 5'd1, 5'd5, 5'd0);
                1: begin
                    applyStimulus(OP_R, 5'd5, 5'd2, 5'd9);
                    reset = 1'b1;
                    expect_at(0, "rst_stall_pending", O_STALL, 16'd1);
                    expect_at(1, "rst_scnt", O_SCNT, 16'd0);
                    expect_at(1, "rst_c2_scnt", C_SCNT, 16'd0);
                    expect_at(1, "rst_fcnt", O_FCNT, 16'd0);
                    expect_at(1, "rst_ex", O_EXB, 16'd0);
                    expect_at(1, "rst_memdst", O_MEMDST, 16'd0);
                end
                2: begin
                    reset = 1'b0;
                    expect_at(0, "rst_no_residue", O_STALL, 16'd0);
                    expect_at(1, "rst_r_ex", O_EXB, 16'h12);
                    expect_at(1, "rst_scnt_after", O_SCNT, 16'd0);
                end
                3: applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
                default: ;
            endcase
            @(negedge clk);
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    obs = observe(sb[k].sel);
                    tests++;
                    if (obs !== sb[k].val) begin
                        failed++;
                        $display("[TB] FAIL %s: observed %0h, expected %0h", sb[k].name, obs, sb[k].val);
                    end
                    sb.delete(k);
                end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        zero_mem = 1'b0;
        applyStimulus(OP_NOP, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_load_use();
        test_branch_beq();
        test_ext_ops();
        test_priority();
        test_saturation_undef();
        test_reset_mid_stall();
        while (sb.size() > 0) begin
            tests++;
            failed++;
            $display("[TB] FAIL unchecked_%s: observed none, expected %0h", sb[0].name, sb[0].val);
            void'(sb.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Pipelined successor to the single-cycle main control decoder.
- Decodes the opcode in ID into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers, together with the destination register.
- Detects load-use hazards, resolves branches in MEM and jumps in ID, and generates the stall, flush and PC-select signals.
- Saturating counters record stall and flush events for performance debug.

Parameters:
RA_W, 5, register address width
HAZARD_EN, 1, 1 = load-use stall logic active; 0 = stall held at 0
EXT_OPS, 1, 1 = decode bne/addi/andi/ori; 0 = those opcodes decode as NOP
CNT_W, 16, width of the saturating event counters

Ports:
clk  input  1  system clock; the block has one clock
reset  input  1  synchronous, active-high reset
op_id  input  6  opcode of the instruction in ID
rs_id  input  RA_W  rs field in ID
rt_id  input  RA_W  rt field in ID
rd_id  input  RA_W  rd field in ID
zero_mem  input  1  ALU zero flag registered into MEM by the datapath
ex_regdst  output  1  EX: select rd as destination
ex_alusrc  output  1  EX: select immediate as ALU operand B
ex_alu_mode  output  3  000 add, 001 sub, 010 funct, 011 and, 100 or
mem_read  output  1  MEM: load
mem_write  output  1  MEM: store
wb_memtoreg  output  1  WB: select memory data
wb_regwrite  output  1  WB: write the register file
ex_dst, mem_dst, wb_dst  output  RA_W each  destination register per stage
stall  output  1  hold PC and IF/ID; insert a bubble into ID/EX
flush_ifid  output  1  squash the IF/ID instruction
pc_src  output  2  00 PC+4, 01 branch target (MEM), 10 jump target (ID)
stall_cnt, flush_cnt  output  CNT_W each  event counters

Behaviour:
- Decode table (combinational, in ID):
  - R 000000: regdst, mode 010, regwrite
  - lw 100011: alusrc, mode 000, memread, memtoreg, regwrite
  - sw 101011: alusrc, mode 000, memwrite
  - beq 000100: mode 001, branch_eq
  - bne 000101: mode 001, branch_ne
  - j 000010: jump_id only, empty bundle
  - addi 001000: alusrc, mode 000, regwrite
  - andi 001100: alusrc, mode 011, regwrite
  - ori 001101: alusrc, mode 100, regwrite
  - Any other opcode decodes to the all-zero NOP bundle.
- Destination register:
  - rd_id when regdst is set.
  - rt_id for lw and I-type ALU ops.
  - 0 otherwise.
  - Carried through the pipeline with its bundle.
- Reset: on a clk edge with reset = 1, every pipeline register, destination register and counter is cleared. All outputs read 0 in the following cycle. Reset mid-stall or mid-flush discards the in-flight state with no residue.
- Pipeline latency: bundle fields appear on ex_* 1 cycle after ID, on mem_* after 2 cycles, on wb_* after 3 cycles.
- Branch taken (combinational from the MEM register):
  - take = (mem_branch_eq & zero_mem) | (mem_branch_ne & ~zero_mem).
  - On take: pc_src = 01 and flush_ifid = 1.
  - Next edge: ID/EX and EX/MEM load NOP bundles with destination 0. MEM/WB advances normally.
- Load-use hazard, when HAZARD_EN = 1: stall = ex_memread & (ex_dst != 0) & ((ex_dst == rs_id & uses_rs) | (ex_dst == rt_id & uses_rt)).
  - uses_rs: every decoded opcode except j and NOP.
  - uses_rt: R, sw, beq, bne.
  - During stall: ID/EX loads a NOP bundle; EX/MEM and MEM/WB advance; the ID instruction is held and re-evaluated next cycle.
  - A lw followed by a dependent instruction therefore gives exactly one stall cycle.
- Jump in ID: pc_src = 10 and flush_ifid = 1; the j bundle (NOP) enters ID/EX.
- Priority, highest first: branch take > stall > jump.
  - take and stall in the same cycle: stall forced to 0.
  - take and jump in the same cycle: pc_src = 01; the jump is squashed.
  - A j in ID never stalls.
- Counters:
  - stall_cnt increments on every cycle where stall = 1 is committed.
  - flush_cnt increments on every cycle with flush_ifid = 1.
  - Both saturate at 2^CNT_W − 1.
- EXT_OPS = 0: bne/addi/andi/ori decode as NOP, with uses_rs = uses_rt = 0.

Test Plan:
1. Reset held for 2 cycles with op_id = 100011 → all outputs 0; after release, lw reaches ex_alusrc = 1 and ex_alu_mode = 000 one cycle later, and wb_memtoreg = 1 with wb_dst = rt three cycles later.
2. lw with rt = 5, then R-type with rs = 5 → stall = 1 for exactly one cycle, NOP in EX, stall_cnt = 1; with rt = 0 or HAZARD_EN = 0 → no stall.
3. beq enters, zero_mem = 1 in MEM → pc_src = 01 and flush_ifid = 1; the next EX and MEM bundles are all-zero; flush_cnt = 1. With zero_mem = 0 → pc_src = 00.
4. bne with zero_mem = 0 → taken; then EXT_OPS = 0 with the same stimulus → never taken, bundle all-zero.
5. j in ID at the same time as a taken branch in MEM → pc_src = 01 (not 10). Branch take together with a load-use hazard → stall = 0 and stall_cnt unchanged.
6. CNT_W = 2 with 5 consecutive stall cycles → stall_cnt = 3 (saturated). An undefined opcode 111111 → all-zero bundle, destination 0.
